mux16_rr_arbiter: RTL and testbench
===================================

MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8: maximum consecutive cycles one requester may own the mux, legal range 1..15.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 REQ  input  16  REQ[i]=1 means requester i wants mux input Xi routed to Z.
REQ-005 REL  input  1  owner's voluntary release, sampled only in OWN.
REQ-006 E  output  1  mux enable, registered.
REQ-007 S  output  4  mux select, registered; equals the owner index while in OWN.
REQ-008 GNT  output  16  one-hot grant, registered; all zero when there is no owner.
REQ-009 BUSY  output  1  registered; 1 exactly while in OWN.

Function
REQ-010 The FSM SHALL have two states: IDLE (no owner) and OWN (owner = S).
REQ-011 The pointer PTR (4 bits) SHALL hold the highest-priority index; the winner is the first set REQ bit scanning PTR, PTR+1, ... 15, 0, ... with mod-16 wrap.
REQ-012 An arbitration event SHALL occur at an edge where either: the state is IDLE; or the state is OWN and a release condition holds.
REQ-013 Release conditions SHALL be: REL=1; REQ[S]=0; or hold counter HCNT = HOLD_MAX-1.
REQ-014 At an arbitration event, if any REQ bit is set:
- the state SHALL become OWN;
- S and GNT SHALL take the winner;
- PTR SHALL become winner+1 mod 16;
- HCNT SHALL clear to 0.
REQ-015 At an arbitration event with REQ=0, the state SHALL become IDLE, GNT=0, and PTR SHALL be unchanged.
REQ-016 Grant latency SHALL be exactly 1 cycle: a REQ sampled at edge n in IDLE drives GNT/S/E valid after edge n.
REQ-017 Handoff SHALL be direct, with no idle cycle: the release edge grants the next winner when another request is pending.
REQ-018 While in OWN with no release condition, HCNT SHALL increment by 1 per cycle and S/GNT SHALL stay stable.
REQ-019 A forced release (HCNT = HOLD_MAX-1) SHALL re-grant the same owner only if no other REQ bit is set, since PTR has already advanced past it.
REQ-020 When REL=1 and a timeout coincide, the result SHALL be a single release, handled identically to either one alone.
REQ-021 In IDLE, REL SHALL be ignored.
REQ-022 In OWN, E SHALL be 1; E in IDLE is defined in REQ-027/028.
REQ-023 HOLD_MAX=1 SHALL cause rotation every cycle among active requesters.

Reset
REQ-024 Asserting RST_N=0 SHALL asynchronously force: state=IDLE, PTR=0, HCNT=0, S=0, GNT=0, BUSY=0, E=0.
REQ-025 Reset asserted mid-ownership SHALL drop the grant immediately, without waiting for a clock.
REQ-026 The first arbitration after RST_N deasserts SHALL occur at the first rising edge after deassertion, with requester 0 at highest priority.

Configuration
REQ-027 With MUX16_ARB_PARK_EN defined, IDLE SHALL hold E=1 and keep S at the last owner (0 after reset), so Z keeps showing the last source.
REQ-028 Without MUX16_ARB_PARK_EN, IDLE SHALL drive E=0 and S=0, so Z is gated off by the mux.

Verification
REQ-029 Reset then REQ=16'h0001 -> one edge later GNT=16'h0001, S=0, E=1, BUSY=1; after 8 cycles of held REQ with no other requester, the same owner is re-granted with HCNT back at 0.
REQ-030 REQ=16'h8001 held, HOLD_MAX=8 -> S alternates 0 (8 cycles), 15 (8 cycles), 0, ...; no IDLE cycle between owners.
REQ-031 Owner S=3 with REQ=16'h0028, REL pulsed 1 cycle -> next edge S=5, GNT=16'h0020, PTR=6.
REQ-032 Owner S=15 drops REQ[15], REQ=16'h0004 -> next edge S=2 (wrap-around scan), PTR=3.
REQ-033 All REQ drop while owning S=7 -> next edge BUSY=0 and GNT=0; E=1, S=7 with MUX16_ARB_PARK_EN, otherwise E=0, S=0.
REQ-034 RST_N pulled low between clock edges while owning S=9 -> GNT=0, E=0, S=0 immediately; after release, REQ=16'hFFFF grants S=0 first.

Source files
------------

// File: rtl/mux16_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux16_rr_arbiter_if
// Description : Request/grant and mux-control bundle for the 16-way
//               round-robin mux arbiter. The slave modport is the arbiter's
//               view. The master modport is the requester / mux side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux16_rr_arbiter_if;
  logic [15:0] req;   // request vector, bit i = requester i
  logic        rel;   // owner's voluntary release
  logic        en;    // mux enable
  logic [3:0]  sel;   // mux select
  logic [15:0] gnt;   // one-hot grant
  logic        busy;  // an owner currently holds the mux

  modport master (
    output req,
    output rel,
    input  en,
    input  sel,
    input  gnt,
    input  busy
  );

  modport slave (
    input  req,
    input  rel,
    output en,
    output sel,
    output gnt,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux16_rr_arbiter
// Description : 16-input round-robin arbiter driving a 16:1 mux select.
//               The FSM has two states, IDLE and OWN. An owner keeps the
//               mux until it releases, drops its request, or uses up
//               HOLD_MAX cycles. The next winner is then taken directly
//               by a rotating-priority scan that starts at PTR.
//               Optional build macro MUX16_ARB_PARK_EN: while IDLE, keep
//               the mux enabled and parked on the last owner. When the
//               macro is undefined, IDLE gates the mux off with sel = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mux16_rr_arbiter #(
  parameter int HOLD_MAX = 8   // legal range 1..15
) (
  input  wire logic         clk_i,
  input  wire logic         rst_n_i,
  mux16_rr_arbiter_if.slave arb_io
);

  // A tenure ends on the edge where the hold count reaches this value.
  localparam logic [3:0] C_HCNT_LAST = 4'(HOLD_MAX - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ptr_q,   ptr_d;
  logic [3:0]  hcnt_q,  hcnt_d;
  logic [3:0]  sel_q,   sel_d;
  logic [15:0] gnt_q,   gnt_d;
  logic        en_q,    en_d;
  logic        busy_q,  busy_d;

  logic [15:0] w_req_rot;
  logic        w_any;
  logic [3:0]  w_off;
  logic [3:0]  w_win;
  logic        w_release;
  logic        w_arb;

  // Rotate the request vector so bit 0 is the requester at PTR. Then find
  // the lowest set bit. The winner is PTR plus that offset, with mod-16
  // wrap from the 4-bit add.
  always_comb begin
    w_req_rot = '0;
    for (int i = 0; i < 16; i++) begin
      w_req_rot[i] = arb_io.req[4'(i) + ptr_q];
    end
    w_any = |arb_io.req;
    w_off = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_off = 4'(i);
      end
    end
    w_win = ptr_q + w_off;
  end

  // Release conditions apply only while owning. In OWN, sel_q is the owner
  // index. If REL and a timeout happen together, they give one release.
  always_comb begin
    w_release = (state_q == ST_OWN) &&
                (arb_io.rel || !arb_io.req[sel_q] || (hcnt_q == C_HCNT_LAST));
    w_arb     = (state_q == ST_IDLE) || w_release;
  end

  // Next-state and next-output selection. Arbitrate on every IDLE edge and
  // on every release edge. Otherwise keep the owner and count its tenure.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    en_d    = en_q;
    busy_d  = busy_q;
    if (w_arb) begin
      hcnt_d = 4'd0;
      if (w_any) begin
        state_d = ST_OWN;
        sel_d   = w_win;
        gnt_d   = 16'd1 << w_win;
        ptr_d   = w_win + 4'd1;
        en_d    = 1'b1;
        busy_d  = 1'b1;
      end else begin
        state_d = ST_IDLE;
        gnt_d   = 16'd0;
        busy_d  = 1'b0;
`ifdef MUX16_ARB_PARK_EN
        // Park: Z keeps showing the last source.
        en_d    = 1'b1;
        sel_d   = sel_q;
`else
        en_d    = 1'b0;
        sel_d   = 4'd0;
`endif
      end
    end else begin
      hcnt_d = hcnt_q + 4'd1;
    end
  end

  // State and registered outputs. Reset is asynchronous, so an in-progress
  // grant drops without waiting for a clock edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= 4'd0;
      hcnt_q  <= 4'd0;
      sel_q   <= 4'd0;
      gnt_q   <= 16'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign arb_io.en   = en_q;
  assign arb_io.sel  = sel_q;
  assign arb_io.gnt  = gnt_q;
  assign arb_io.busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux16_rr_arbiter
// Description : Self-checking bench for mux16_rr_arbiter. Two instances run
//               side by side, one with HOLD_MAX=8 and one with HOLD_MAX=1.
//               The bench applies directed vectors, corner-case sequences,
//               and random traffic checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux16_rr_arbiter;

  localparam bit PARK =
`ifdef MUX16_ARB_PARK_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux16_rr_arbiter_if a0 ();
  mux16_rr_arbiter_if a1 ();

  mux16_rr_arbiter #(.HOLD_MAX(8)) dut0 (.clk_i(clk), .rst_n_i(rst_n), .arb_io(a0));
  mux16_rr_arbiter #(.HOLD_MAX(1)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .arb_io(a1));

  int nvec = 0;
  int nbad = 0;

  // Behavioural model: owner index (-1 = none), priority pointer, cycles
  // owned so far, the last owner, and whether any edge has passed since reset.
  typedef struct {
    int owner;
    int ptr;
    int held;
    int last;
    bit armed;
  } mstate_t;

  mstate_t m0, m1;

  function automatic mstate_t mreset();
    mstate_t m;
    m.owner = -1; m.ptr = 0; m.held = 0; m.last = 0; m.armed = 1'b0;
    return m;
  endfunction

  function automatic mstate_t mstep(mstate_t m, logic [15:0] req, logic rel, int hmax);
    mstate_t n = m;
    bit rearb;
    int w;
    rearb = (m.owner < 0) || rel || (req[m.owner] == 1'b0) || (m.held >= hmax);
    if (rearb) begin
      w = -1;
      for (int k = 0; k < 16; k++) begin
        if (w < 0 && req[(m.ptr + k) % 16]) w = (m.ptr + k) % 16;
      end
      if (w >= 0) begin
        n.owner = w; n.ptr = (w + 1) % 16; n.held = 1; n.last = w;
      end else begin
        n.owner = -1;
      end
    end else begin
      n.held = m.held + 1;
    end
    n.armed = 1'b1;
    return n;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    nvec++;
    if (act !== want) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic chk_model(input string tag, input mstate_t m, input logic [15:0] gnt,
                           input logic [3:0] sel, input logic en, input logic busy);
    bit own;
    own = (m.owner >= 0);
    chk({tag, ".gnt"},  gnt,  own ? (16'd1 << m.owner) : 16'd0);
    chk({tag, ".sel"},  16'(sel), own ? 16'(m.owner) : ((PARK && m.armed) ? 16'(m.last) : 16'd0));
    chk({tag, ".en"},   16'(en),   16'(own || (PARK && m.armed)));
    chk({tag, ".busy"}, 16'(busy), 16'(own));
  endtask

  task automatic setin(input logic [15:0] req, input logic rel);
    a0.req = req; a0.rel = rel;
    a1.req = req; a1.rel = rel;
  endtask

  // One rising edge: advance both models, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    m0 = mstep(m0, a0.req, a0.rel, 8);
    m1 = mstep(m1, a1.req, a1.rel, 1);
    #1;
  endtask

  task automatic do_reset();
    setin(16'd0, 1'b0);
    rst_n = 1'b0;
    m0 = mreset();
    m1 = mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.gnt",  a0.gnt, 16'd0);
    chk("rst.sel",  16'(a0.sel), 16'd0);
    chk("rst.en",   16'(a0.en), 16'd0);
    chk("rst.busy", 16'(a0.busy), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] req;
    logic        rel;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        en;
    logic        busy;
    logic [3:0]  ptr;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Directed vectors, applied in order from reset (PTR starts at 0).
    tbl[0]  = '{16'h0001, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b1, 4'd1};
    tbl[1]  = '{16'h0028, 1'b0, 16'h0008, 4'd3,  1'b1, 1'b1, 4'd4};
    tbl[2]  = '{16'h0028, 1'b1, 16'h0020, 4'd5,  1'b1, 1'b1, 4'd6};
    tbl[3]  = '{16'h0020, 1'b0, 16'h0020, 4'd5,  1'b1, 1'b1, 4'd6};
    tbl[4]  = '{16'h8000, 1'b0, 16'h8000, 4'd15, 1'b1, 1'b1, 4'd0};
    tbl[5]  = '{16'h0004, 1'b0, 16'h0004, 4'd2,  1'b1, 1'b1, 4'd3};
    tbl[6]  = '{16'h0000, 1'b0, 16'h0000, PARK ? 4'd2 : 4'd0, PARK, 1'b0, 4'd3};
    tbl[7]  = '{16'h0000, 1'b1, 16'h0000, PARK ? 4'd2 : 4'd0, PARK, 1'b0, 4'd3};
    tbl[8]  = '{16'hFFFF, 1'b0, 16'h0008, 4'd3,  1'b1, 1'b1, 4'd4};
    tbl[9]  = '{16'hFFFF, 1'b1, 16'h0010, 4'd4,  1'b1, 1'b1, 4'd5};
    tbl[10] = '{16'h0100, 1'b0, 16'h0100, 4'd8,  1'b1, 1'b1, 4'd9};
    tbl[11] = '{16'h0300, 1'b0, 16'h0100, 4'd8,  1'b1, 1'b1, 4'd9};
    tbl[12] = '{16'h0300, 1'b1, 16'h0200, 4'd9,  1'b1, 1'b1, 4'd10};
    tbl[13] = '{16'h0001, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b1, 4'd1};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      setin(tbl[i].req, tbl[i].rel);
      tick();
      chk($sformatf("tbl%0d.gnt", i),  a0.gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d.sel", i),  16'(a0.sel), 16'(tbl[i].sel));
      chk($sformatf("tbl%0d.en", i),   16'(a0.en), 16'(tbl[i].en));
      chk($sformatf("tbl%0d.busy", i), 16'(a0.busy), 16'(tbl[i].busy));
      chk($sformatf("tbl%0d.ptr", i),  16'(dut0.ptr_q), 16'(tbl[i].ptr));
    end

    // Single requester: tenure expires every 8 cycles and is re-granted
    // with no gap. The hold count restarts at 0.
    do_reset();
    setin(16'h0001, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("solo%0d.gnt", k),  a0.gnt, 16'h0001);
      chk($sformatf("solo%0d.busy", k), 16'(a0.busy), 16'd1);
      chk($sformatf("solo%0d.hcnt", k), 16'(dut0.hcnt_q), 16'(k % 8));
    end

    // Two steady requesters: 8-cycle alternation on dut0, and every-cycle
    // alternation on dut1.
    do_reset();
    setin(16'h8001, 1'b0);
    for (int k = 0; k < 40; k++) begin
      tick();
      chk($sformatf("alt8_%0d.sel", k),  16'(a0.sel), ((k / 8) % 2 == 0) ? 16'd0 : 16'd15);
      chk($sformatf("alt8_%0d.busy", k), 16'(a0.busy), 16'd1);
      chk($sformatf("alt1_%0d.sel", k),  16'(a1.sel), (k % 2 == 0) ? 16'd0 : 16'd15);
    end

    // All requests drop while requester 7 owns the mux.
    do_reset();
    setin(16'h0080, 1'b0);
    tick();
    chk("own7.sel", 16'(a0.sel), 16'd7);
    setin(16'h0000, 1'b0);
    tick();
    chk("drop7.busy", 16'(a0.busy), 16'd0);
    chk("drop7.gnt",  a0.gnt, 16'd0);
    chk("drop7.en",   16'(a0.en), 16'(PARK));
    chk("drop7.sel",  16'(a0.sel), PARK ? 16'd7 : 16'd0);

    // Asynchronous reset between edges while requester 9 owns the mux.
    do_reset();
    setin(16'h0200, 1'b0);
    tick();
    chk("own9.sel", 16'(a0.sel), 16'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.gnt",  a0.gnt, 16'd0);
    chk("arst.en",   16'(a0.en), 16'd0);
    chk("arst.sel",  16'(a0.sel), 16'd0);
    chk("arst.busy", 16'(a0.busy), 16'd0);
    m0 = mreset();
    m1 = mreset();
    setin(16'hFFFF, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_arst.sel", 16'(a0.sel), 16'd0);
    chk("post_arst.gnt", a0.gnt, 16'h0001);

    // Random traffic on both instances, checked against the model. Requests
    // change only now and then, so that some tenures run to the timeout.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      logic [15:0] r;
      if ($urandom_range(0, 3) == 0 || k == 0) begin
        r = 16'($urandom);
        case ($urandom_range(0, 3))
          0: r = r & 16'($urandom) & 16'($urandom);
          1: r = 16'd1 << $urandom_range(0, 15);
          2: r = (k % 7 == 0) ? 16'd0 : r;
          default: ;
        endcase
      end else begin
        r = a0.req;
      end
      setin(r, ($urandom_range(0, 5) == 0));
      tick();
      chk_model($sformatf("rnd8_%0d", k), m0, a0.gnt, a0.sel, a0.en, a0.busy);
      chk_model($sformatf("rnd1_%0d", k), m1, a1.gnt, a1.sel, a1.en, a1.busy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
`default_nettype wire
